qa_sample_packer: RTL and testbench

//  Transmit-side framer for the QA datapath. Accepts 32-bit samples qualified by single-cycle
//  new-data pulses (the qa_wrapper out_data/out_nd convention) and emits fixed-length frames on
//  a 36-bit fifo36 stream (bit32 SOF, bit33 EOF, bits35:34 occupancy) toward the host rx path.

---
 rtl/qa_sample_packer_if.sv | 11 +
 rtl/qa_sample_packer.sv | 169 ++++++++++++++++
 tb/tb_qa_sample_packer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/qa_sample_packer_if.sv
// Sample-in / fifo36-out stream bundle for qa_sample_packer; slave is the packer side.
interface qa_sample_packer_if;
  logic [31:0] in_data;
  logic        in_nd;
  logic [35:0] data_o;
  logic        src_rdy_o;
  logic        dst_rdy_i;

  modport master (output in_data, in_nd, dst_rdy_i, input data_o, src_rdy_o);
  modport slave  (input in_data, in_nd, dst_rdy_i, output data_o, src_rdy_o);
endinterface

// File: rtl/qa_sample_packer.sv
// Frames strobed 32-bit samples into fifo36 packets; header is valid the cycle after a frame's last sample is
// strobed; host back-pressure only fills the sample buffer. Optional TS word: QA_PACKER_TIMESTAMP_EN.
module qa_sample_packer #(
  parameter int          FIFO_LOG      = 4,
  parameter int          SAMPS_PER_PKT = 8,
  parameter logic [15:0] SID           = 16'd20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  qa_sample_packer_if.slave bus,
  output logic              overrun,
  output logic [3:0]        seq_o
);
  localparam int                  DEPTH    = 1 << FIFO_LOG;
  localparam logic [FIFO_LOG:0]   CNT_FULL = (FIFO_LOG+1)'(DEPTH);
  localparam logic [FIFO_LOG:0]   CNT_PKT  = (FIFO_LOG+1)'(SAMPS_PER_PKT);
  localparam logic [FIFO_LOG:0]   CNT_ONE  = (FIFO_LOG+1)'(1);
  localparam logic [FIFO_LOG-1:0] PTR_ONE  = FIFO_LOG'(1);
  localparam logic [FIFO_LOG-1:0] LAST_IDX = FIFO_LOG'(SAMPS_PER_PKT - 1);
`ifdef QA_PACKER_TIMESTAMP_EN
  localparam int LEN = SAMPS_PER_PKT + 2;
`else
  localparam int LEN = SAMPS_PER_PKT + 1;
`endif
  localparam logic [11:0] LEN_C = 12'(LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
`ifdef QA_PACKER_TIMESTAMP_EN
  localparam logic [1:0] S_TS   = 2'd3;
`endif

  logic [31:0]         r_mem [DEPTH];
  logic [FIFO_LOG-1:0] r_wr_ptr;
  logic [FIFO_LOG-1:0] r_rd_ptr;
  logic [FIFO_LOG-1:0] r_samp_cnt;
  logic [FIFO_LOG:0]   r_count;
  logic [1:0]          r_state;
  logic [3:0]          r_seq;
  logic                r_overrun;

  logic [FIFO_LOG:0]   w_avail;
  logic                w_full;
  logic                w_xfer;
  logic                w_pop;
  logic                w_push;
  logic                w_go;
  logic                w_last;
  logic [35:0]         w_data;
  logic                w_src_rdy;

  assign w_full  = (r_count == CNT_FULL);
  assign w_xfer  = w_src_rdy & bus.dst_rdy_i;
  assign w_pop   = w_xfer && (r_state == S_DATA);
  // A pop frees the slot in the same edge, so a full buffer still accepts a coincident sample.
  assign w_push  = bus.in_nd && !clear && (!w_full || w_pop);
  // Counting the sample arriving this cycle lets the header appear one cycle after the last strobe.
  assign w_avail = r_count + {{FIFO_LOG{1'b0}}, w_push};
  assign w_go    = (r_state == S_IDLE) && (w_avail >= CNT_PKT);
  assign w_last  = (r_samp_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_samp_cnt <= '0;
      r_seq      <= '0;
      r_overrun  <= 1'b0;
    end else if (clear) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_samp_cnt <= '0;
      r_seq      <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
      if (bus.in_nd && !w_push) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state    <= S_HDR;
            r_samp_cnt <= '0;
          end
        end
        S_HDR: begin
`ifdef QA_PACKER_TIMESTAMP_EN
          if (w_xfer) r_state <= S_TS;
`else
          if (w_xfer) r_state <= S_DATA;
`endif
        end
`ifdef QA_PACKER_TIMESTAMP_EN
        S_TS: begin
          if (w_xfer) r_state <= S_DATA;
        end
`endif
        S_DATA: begin
          if (w_xfer) begin
            r_samp_cnt <= r_samp_cnt + PTR_ONE;
            if (w_last) begin
              r_state <= S_IDLE;
              r_seq   <= r_seq + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef QA_PACKER_TIMESTAMP_EN
  logic [31:0] r_cycle;
  logic [31:0] r_ts;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle <= '0;
      r_ts    <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_go && !clear) r_ts <= r_cycle;
    end
  end
`endif

  always_comb begin
    w_src_rdy = 1'b0;
    w_data    = '0;
    case (r_state)
      S_HDR: begin
        w_src_rdy = 1'b1;
        w_data    = {2'b00, 1'b0, 1'b1, SID, r_seq, LEN_C};
      end
`ifdef QA_PACKER_TIMESTAMP_EN
      S_TS: begin
        w_src_rdy = 1'b1;
        w_data    = {4'b0000, r_ts};
      end
`endif
      S_DATA: begin
        w_src_rdy = 1'b1;
        w_data    = {2'b00, w_last, 1'b0, r_mem[r_rd_ptr]};
      end
      default: begin
        w_src_rdy = 1'b0;
        w_data    = '0;
      end
    endcase
  end

  assign bus.data_o    = w_data;
  assign bus.src_rdy_o = w_src_rdy;
  assign overrun       = r_overrun;
  assign seq_o         = r_seq;
endmodule

// File: tb/tb_qa_sample_packer.sv
// Directed bench for qa_sample_packer: framing, overrun, full-buffer push/pop, stalls and clear.
module tb_qa_sample_packer;
  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear   = 1'b0;
  logic       overrun;
  logic [3:0] seq_o;
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

`ifdef QA_PACKER_TIMESTAMP_EN
  localparam logic [11:0] LEN = 12'd10;
  localparam int          NW  = 10;
`else
  localparam logic [11:0] LEN = 12'd9;
  localparam int          NW  = 9;
`endif

  qa_sample_packer_if bus ();

  qa_sample_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus),
    .overrun (overrun),
    .seq_o   (seq_o)
  );

  always #5 clk = ~clk;

`ifdef QA_PACKER_TIMESTAMP_EN
  logic [31:0] cyc = 32'd0;
  logic [31:0] ts_exp = 32'd0;
  logic        prev_src = 1'b0;
  always @(posedge clk) if (reset_n) cyc <= cyc + 32'd1;
  always @(negedge clk) begin
    if (bus.src_rdy_o && !prev_src) ts_exp = cyc - 32'd1;
    prev_src = bus.src_rdy_o;
  end
`endif

  function automatic logic [35:0] hdr(input logic [3:0] s);
    return {4'b0001, 16'h0014, s, LEN};
  endfunction

  function automatic logic [35:0] smp(input logic [31:0] v, input logic eof);
    return {2'b00, eof, 1'b0, v};
  endfunction

  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    bus.in_nd   = 1'b1;
    bus.in_data = v;
    @(negedge clk);
    bus.in_nd   = 1'b0;
  endtask

  // Waits (bounded) for src_rdy, checks the word, then lets it transfer (dst_rdy_i must be 1).
  task automatic expect_word(input string tag, input logic [35:0] exp);
    int n = 0;
    while (!bus.src_rdy_o && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {bus.src_rdy_o, bus.data_o}, {1'b1, exp});
    @(negedge clk);
  endtask

  task automatic expect_hdr(input string tag, input logic [3:0] s);
    expect_word({tag, "_hdr"}, hdr(s));
`ifdef QA_PACKER_TIMESTAMP_EN
    expect_word({tag, "_ts"}, {4'b0000, ts_exp});
`endif
  endtask

  task automatic expect_frame(input string tag, input logic [3:0] s, input logic [31:0] base);
    expect_hdr(tag, s);
    for (int k = 1; k <= 8; k++) expect_word({tag, "_smp"}, smp(base + 32'(k), k == 8));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic [35:0] exp4 [10];
  int          idx;
  int          guard;

  initial begin
    bus.in_data   = '0;
    bus.in_nd     = 1'b0;
    bus.dst_rdy_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", {bus.src_rdy_o, bus.data_o}, 37'd0);
    chk("rst_ovr", 37'(overrun), 37'd0);
    chk("rst_seq", 37'(seq_o), 37'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // basic frame, header latency
    bus.dst_rdy_i = 1'b1;
    for (int i = 1; i <= 7; i++) push(32'(i));
    chk("t1_idle_at7", 37'(bus.src_rdy_o), 37'd0);
    push(32'd8);
    chk("t1_hdr_latency", {bus.src_rdy_o, bus.data_o}, {1'b1, 36'h1_0014_0000 | 36'(LEN)});
    expect_frame("t1", 4'd0, 32'd0);
    chk("t1_eof_word_const", 37'(smp(32'd8, 1'b1)), 37'h2_0000_0008);
    chk("t1_idle_after", 37'(bus.src_rdy_o), 37'd0);
    chk("t1_seq", 37'(seq_o), 37'd1);

    // overrun with stalled consumer
    do_clear();
    chk("t2_clr_src", 37'(bus.src_rdy_o), 37'd0);
    chk("t2_clr_seq", 37'(seq_o), 37'd0);
    bus.dst_rdy_i = 1'b0;
    for (int i = 1; i <= 17; i++) push(32'h100 + 32'(i));
    chk("t2_ovr_set", 37'(overrun), 37'd1);
    chk("t2_hdr_held", {bus.src_rdy_o, bus.data_o}, {1'b1, hdr(4'd0)});
    bus.dst_rdy_i = 1'b1;
    expect_frame("t2a", 4'd0, 32'h100);
    chk("t2_gap_idle", 37'(bus.src_rdy_o), 37'd0);
    @(negedge clk);
    chk("t2_sof_after_gap", 37'(bus.src_rdy_o), 37'd1);
    expect_frame("t2b", 4'd1, 32'h108);
    chk("t2_ovr_sticky", 37'(overrun), 37'd1);
    chk("t2_seq", 37'(seq_o), 37'd2);
    chk("t2_drained", 37'(bus.src_rdy_o), 37'd0);

    // full buffer, write coinciding with a pop
    do_clear();
    chk("t3_clr_ovr", 37'(overrun), 37'd0);
    bus.dst_rdy_i = 1'b0;
    for (int i = 1; i <= 16; i++) push(32'h200 + 32'(i));
    chk("t3_full_noovr", 37'(overrun), 37'd0);
    bus.dst_rdy_i = 1'b1;
    expect_hdr("t3a", 4'd0);
    bus.in_nd   = 1'b1;
    bus.in_data = 32'h211;
    expect_word("t3a_s1", smp(32'h201, 1'b0));
    bus.in_nd   = 1'b0;
    chk("t3_pushpop_noovr", 37'(overrun), 37'd0);
    for (int k = 2; k <= 8; k++) expect_word("t3a_smp", smp(32'h200 + 32'(k), k == 8));
    expect_frame("t3b", 4'd1, 32'h208);
    for (int i = 0; i < 7; i++) push(32'h212 + 32'(i));
    expect_frame("t3c", 4'd2, 32'h210);

    // random stalls: word must hold until it transfers
    bus.dst_rdy_i = 1'b0;
    for (int i = 1; i <= 8; i++) push(32'h400 + 32'(i));
    exp4[0] = hdr(4'd3);
`ifdef QA_PACKER_TIMESTAMP_EN
    exp4[1] = {4'b0000, ts_exp};
`endif
    for (int k = 1; k <= 8; k++) exp4[NW - 9 + k] = smp(32'h400 + 32'(k), k == 8);
    idx   = 0;
    guard = 0;
    while (idx < NW && guard < 300) begin
      chk("t4_hold", {bus.src_rdy_o, bus.data_o}, {1'b1, exp4[idx]});
      bus.dst_rdy_i = 1'($urandom_range(0, 1));
      if (bus.dst_rdy_i) idx++;
      @(negedge clk);
      guard++;
    end
    chk("t4_xfers", 37'(idx), 37'(NW));
    chk("t4_end_idle", 37'(bus.src_rdy_o), 37'd0);
    chk("t4_seq", 37'(seq_o), 37'd4);
    bus.dst_rdy_i = 1'b1;

    // clear mid-frame
    for (int i = 1; i <= 8; i++) push(32'h500 + 32'(i));
    expect_hdr("t5a", 4'd4);
    for (int k = 1; k <= 3; k++) expect_word("t5a_smp", smp(32'h500 + 32'(k), 1'b0));
    clear       = 1'b1;
    bus.in_nd   = 1'b1;
    bus.in_data = 32'h5FF;
    @(negedge clk);
    clear     = 1'b0;
    bus.in_nd = 1'b0;
    chk("t5_clr_src", 37'(bus.src_rdy_o), 37'd0);
    chk("t5_clr_seq", 37'(seq_o), 37'd0);
    for (int i = 1; i <= 8; i++) push(32'h510 + 32'(i));
    expect_frame("t5b", 4'd0, 32'h510);
    chk("t5_seq", 37'(seq_o), 37'd1);
    chk("t5_ovr", 37'(overrun), 37'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
